// File: rtl/pixel_stream_pkg.sv
// Shared types and default sizing for the pixel stream source.
// Contents: state encoding, default pixel/frame/coordinate widths,
// and the frame-marker payload carried alongside each pixel.
package pixel_stream_pkg;

  localparam int unsigned PIXEL_W_DEFAULT = 24;
  localparam int unsigned FRAME_W_DEFAULT = 640;
  localparam int unsigned FRAME_H_DEFAULT = 480;
  localparam int unsigned XY_W_DEFAULT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } frame_marker_t;

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster position counter for one frame.
// Ports:
//   clk, resetn     - clock, async active-low reset
//   clear           - synchronous return to (0,0)
//   inc             - advance one pixel in raster order
//   x, y            - current column / row
//   last_x          - current column is the last of the line
//   last_frame      - current position is the last pixel of the frame
module pixel_xy_counter
  import pixel_stream_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
  parameter int unsigned FRAME_H = FRAME_H_DEFAULT,
  parameter int unsigned XY_W    = XY_W_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            inc,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y,
  output logic            last_x,
  output logic            last_frame
);

  logic [XY_W-1:0] x_q, x_d;
  logic [XY_W-1:0] y_q, y_d;

  assign x          = x_q;
  assign y          = y_q;
  assign last_x     = (x_q == XY_W'(FRAME_W - 1));
  assign last_frame = last_x && (y_q == XY_W'(FRAME_H - 1));

  // Raster advance: x wraps at end of line, y wraps at end of frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_frame ? '0 : y_q + XY_W'(1);
      end else begin
        x_d = x_q + XY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Pixel stream source feeding the darkest-pixel filter.
// On start: clears the filter for one cycle, pulls exactly one frame from an
// upstream ready/valid source, re-presents each pixel one cycle later with
// its coordinates and frame markers, then pulses done.
// Ports:
//   clk, resetn              - clock, async active-low reset
//   start                    - frame request (ignored while busy)
//   busy, done               - frame in progress / end-of-frame pulse
//   s_pixel, s_valid, s_ready- upstream ready/valid pixel source
//   pixel_out, valid_out     - pixel to the filter and its qualifier
//   filter_resetn            - active-low filter clear
//   x_out, y_out             - coordinates of pixel_out
//   sof, eol, eof            - frame markers qualified by valid_out
// Optional (PIXEL_STREAM_TX_ABORT_EN): abort input, aborted output.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int unsigned PIXEL_W = PIXEL_W_DEFAULT,
  parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
  parameter int unsigned FRAME_H = FRAME_H_DEFAULT,
  parameter int unsigned XY_W    = XY_W_DEFAULT
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [PIXEL_W-1:0] s_pixel,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               valid_out,
  output logic               filter_resetn,
  output logic [XY_W-1:0]    x_out,
  output logic [XY_W-1:0]    y_out,
  output logic               sof,
  output logic               eol,
  output logic               eof
`ifdef PIXEL_STREAM_TX_ABORT_EN
  ,
  input  logic               abort,
  output logic               aborted
`endif
);

  state_e state_q, state_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               s_ready_q, s_ready_d;
  logic               filter_resetn_q, filter_resetn_d;
  logic               valid_out_q, valid_out_d;
  logic [PIXEL_W-1:0] pixel_out_q, pixel_out_d;
  logic [XY_W-1:0]    x_out_q, x_out_d;
  logic [XY_W-1:0]    y_out_q, y_out_d;
  frame_marker_t      marker_q, marker_d;

  logic               abort_req;
  logic               xfer;
  logic [XY_W-1:0]    cnt_x, cnt_y;
  logic               cnt_last_x, cnt_last_frame;

`ifdef PIXEL_STREAM_TX_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_req = abort && (state_q != IDLE);
  // Abort wins over a same-cycle handshake, so ready is withdrawn at once.
  assign s_ready   = s_ready_q && !abort;
  assign aborted_d = abort_req;
  assign aborted   = aborted_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) aborted_q <= 1'b0;
    else         aborted_q <= aborted_d;
  end
`else
  assign abort_req = 1'b0;
  assign s_ready   = s_ready_q;
`endif

  // Upstream handshake; ready is only ever registered high in STREAM.
  assign xfer = (state_q == STREAM) && s_valid && s_ready_q && !abort_req;

  pixel_xy_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .XY_W    (XY_W)
  ) u_xy (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (state_q == CLEAR),
    .inc        (xfer),
    .x          (cnt_x),
    .y          (cnt_y),
    .last_x     (cnt_last_x),
    .last_frame (cnt_last_frame)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = STREAM;
      STREAM:  if (xfer && cnt_last_frame) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_req) state_d = IDLE;
  end

  // Output logic: values for the cycle after this edge, decoded from state_d.
  always_comb begin
    busy_d          = (state_d != IDLE);
    done_d          = (state_q != IDLE) && (state_d == IDLE);
    s_ready_d       = (state_d == STREAM);
    filter_resetn_d = (state_d != CLEAR);
    valid_out_d     = xfer;
    pixel_out_d     = pixel_out_q;
    x_out_d         = x_out_q;
    y_out_d         = y_out_q;
    marker_d        = '0;
    if (xfer) begin
      pixel_out_d  = s_pixel;
      x_out_d      = cnt_x;
      y_out_d      = cnt_y;
      marker_d.sof = (cnt_x == '0) && (cnt_y == '0);
      marker_d.eol = cnt_last_x;
      marker_d.eof = cnt_last_frame;
    end
  end

  // Output registers; filter held in clear while the system is in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      s_ready_q       <= 1'b0;
      filter_resetn_q <= 1'b0;
      valid_out_q     <= 1'b0;
      pixel_out_q     <= '0;
      x_out_q         <= '0;
      y_out_q         <= '0;
      marker_q        <= '0;
    end else begin
      busy_q          <= busy_d;
      done_q          <= done_d;
      s_ready_q       <= s_ready_d;
      filter_resetn_q <= filter_resetn_d;
      valid_out_q     <= valid_out_d;
      pixel_out_q     <= pixel_out_d;
      x_out_q         <= x_out_d;
      y_out_q         <= y_out_d;
      marker_q        <= marker_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign filter_resetn = filter_resetn_q;
  assign valid_out     = valid_out_q;
  assign pixel_out     = pixel_out_q;
  assign x_out         = x_out_q;
  assign y_out         = y_out_q;
  assign sof           = marker_q.sof;
  assign eol           = marker_q.eol;
  assign eof           = marker_q.eof;

endmodule
